// File: rtl/ps_packet_arbiter.sv
// rtl/ps_packet_arbiter.sv - packet-locked round-robin arbiter merging INPUTS streams into one sink
// Optional PS_PACKET_ARBITER_OUTREG_EN adds a two-entry output skid stage (one cycle latency).
module ps_packet_arbiter #(
  parameter int DWIDTH = 8,
  parameter int INPUTS = 4,
  parameter int SWIDTH = $clog2(INPUTS)
) (
  input  logic                     reset,
  input  logic                     clk,
  input  logic [INPUTS*DWIDTH-1:0] i_dat,
  input  logic [INPUTS-1:0]        i_val,
  input  logic [INPUTS-1:0]        i_eop,
  output logic [INPUTS-1:0]        i_rdy,
  output logic [DWIDTH-1:0]        o_dat,
  output logic                     o_val,
  output logic                     o_eop,
  input  logic                     o_rdy,
  output logic [SWIDTH-1:0]        o_sel
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

  lock_t             lock_reg, lock_nxt;
  logic [SWIDTH-1:0] sel_reg, sel_nxt;
  logic [SWIDTH-1:0] ptr_reg, ptr_nxt;

  logic [SWIDTH-1:0] scan_gnt;
  logic              scan_hit;
  logic [SWIDTH-1:0] scan_idx;
  int                idx;

  logic [SWIDTH-1:0] gnt;
  logic [DWIDTH-1:0] mux_dat;
  logic              mux_val;
  logic              mux_eop;
  logic [SWIDTH-1:0] mux_sel;
  logic              mux_rdy;
  logic              mux_xfer;
  logic              sink_rdy;
  logic              active;

  function automatic logic [SWIDTH-1:0] wrap_inc(input logic [SWIDTH-1:0] v);
    return (v == SWIDTH'(INPUTS - 1)) ? '0 : v + 1'b1;
  endfunction

  // Scan from the highest offset down so the lowest offset from ptr_reg wins.
  always_comb begin
    scan_gnt = ptr_reg;
    scan_hit = 1'b0;
    idx      = 0;
    scan_idx = '0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      idx = int'(ptr_reg) + i;
      if (idx >= INPUTS) idx = idx - INPUTS;
      scan_idx = SWIDTH'(idx);
      if (i_val[scan_idx]) begin
        scan_gnt = scan_idx;
        scan_hit = 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    gnt      = (lock_reg == LOCKED) ? sel_reg : scan_gnt;
    active   = reset & ((lock_reg == LOCKED) | scan_hit);
    mux_dat  = i_dat[int'(gnt) * DWIDTH +: DWIDTH];
    mux_val  = reset & i_val[gnt];
    mux_eop  = reset & i_eop[gnt];
    mux_sel  = reset ? gnt : '0;
    mux_rdy  = active & sink_rdy;
    mux_xfer = mux_val & mux_rdy;
    i_rdy    = '0;
    i_rdy[gnt] = mux_rdy;
  end

  always_comb begin
    lock_nxt = lock_reg;
    sel_nxt  = sel_reg;
    ptr_nxt  = ptr_reg;
    if (mux_xfer) begin
      case (lock_reg)
        IDLE: begin
          if (mux_eop) begin
            ptr_nxt = wrap_inc(gnt);
          end else begin
            lock_nxt = LOCKED;
            sel_nxt  = gnt;
          end
        end
        LOCKED: begin
          if (mux_eop) begin
            lock_nxt = IDLE;
            ptr_nxt  = wrap_inc(sel_reg);
          end
        end
        default: lock_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_reg <= IDLE;
      sel_reg  <= '0;
      ptr_reg  <= '0;
    end else begin
      lock_reg <= lock_nxt;
      sel_reg  <= sel_nxt;
      ptr_reg  <= ptr_nxt;
    end
  end

`ifdef PS_PACKET_ARBITER_OUTREG_EN
  localparam int EW = SWIDTH + DWIDTH + 1;

  logic [1:0]    cnt;
  logic [EW-1:0] ent0, ent1;
  logic [EW-1:0] mux_ent;
  logic          push, pop;

  // Ready toward the mux depends only on occupancy, breaking the o_rdy -> i_rdy path.
  assign sink_rdy = (cnt != 2'd2);
  assign mux_ent  = {mux_sel, mux_eop, mux_dat};
  assign push     = mux_xfer;
  assign pop      = (cnt != 2'd0) & o_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= mux_ent;
          else             ent1 <= mux_ent;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) ent0 <= mux_ent;
          else begin
            ent0 <= ent1;
            ent1 <= mux_ent;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  assign o_val = (cnt != 2'd0);
  assign o_sel = ent0[EW-1 -: SWIDTH];
  assign o_eop = ent0[DWIDTH];
  assign o_dat = ent0[DWIDTH-1:0];
`else
  assign sink_rdy = o_rdy;
  assign o_val    = mux_val;
  assign o_eop    = mux_eop;
  assign o_dat    = mux_dat;
  assign o_sel    = mux_sel;
`endif

endmodule

// File: tb/tb_ps_packet_arbiter.sv
// tb/tb_ps_packet_arbiter.sv - self-checking bench for ps_packet_arbiter
module tb_ps_packet_arbiter;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*DW-1:0] i_dat;
  logic [N-1:0]    i_val, i_eop, i_rdy;
  logic [DW-1:0]   o_dat;
  logic            o_val, o_eop, o_rdy;
  logic [SW-1:0]   o_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps_packet_arbiter #(.DWIDTH(DW), .INPUTS(N)) dut (
    .reset(reset), .clk(clk),
    .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy), .o_sel(o_sel)
  );

  task automatic clear_inputs();
    i_dat = '0; i_val = '0; i_eop = '0; o_rdy = 1'b0;
  endtask

  task automatic put(input int k, input logic v, input logic [DW-1:0] d, input logic e);
    i_val[k] = v;
    i_dat[k*DW +: DW] = d;
    i_eop[k] = e;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_val = '1; i_eop = '1; i_dat = '1; o_rdy = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (i_rdy !== '0) begin failures++; $display("FAIL reset_i_rdy got=%b exp=0", i_rdy); end
    checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL reset_o_val got=%b exp=0", o_val); end
    checks++; if (o_eop !== 1'b0) begin failures++; $display("FAIL reset_o_eop got=%b exp=0", o_eop); end
    checks++; if (o_sel !== '0) begin failures++; $display("FAIL reset_o_sel got=%0d exp=0", o_sel); end
    next_cycle();
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_source();
    do_reset();
    o_rdy = 1'b1;
    for (int w = 0; w < 3; w++) begin
      put(2, 1'b1, DW'(8'hA0 + w), w == 2);
      @(negedge clk);
      checks++;
      if (o_val !== 1'b1 || o_dat !== DW'(8'hA0 + w) || o_sel !== SW'(2) || o_eop !== (w == 2)) begin
        failures++;
        $display("FAIL single_word%0d got val=%b dat=%h sel=%0d eop=%b exp val=1 dat=%h sel=2 eop=%b",
                 w, o_val, o_dat, o_sel, o_eop, DW'(8'hA0 + w), w == 2);
      end
      next_cycle();
    end
    put(2, 1'b0, '0, 1'b0);
    put(0, 1'b1, 8'h50, 1'b1);
    put(3, 1'b1, 8'h53, 1'b1);
    @(negedge clk);
    checks++; if (o_sel !== SW'(3)) begin failures++; $display("FAIL single_ptr got sel=%0d exp=3", o_sel); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_contention();
    int widx [N];
    int es, ew;
    do_reset();
    o_rdy = 1'b1;
    for (int k = 0; k < N; k++) widx[k] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < N; k++) put(k, 1'b1, DW'((k << 4) | widx[k]), widx[k] == 1);
      @(negedge clk);
      es = (c / 2) % N;
      ew = c % 2;
      checks++;
      if (o_val !== 1'b1 || o_sel !== SW'(es) || o_dat !== DW'((es << 4) | ew) || o_eop !== (ew == 1)) begin
        failures++;
        $display("FAIL contention_c%0d got sel=%0d dat=%h eop=%b exp sel=%0d dat=%h eop=%b",
                 c, o_sel, o_dat, o_eop, es, DW'((es << 4) | ew), ew == 1);
      end
      checks++; if (!$onehot0(i_rdy)) begin failures++; $display("FAIL contention_onehot got=%b exp=onehot0", i_rdy); end
      for (int k = 0; k < N; k++) if (i_rdy[k]) widx[k] = (widx[k] + 1) % 2;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_bubble();
    do_reset();
    o_rdy = 1'b1;
    put(1, 1'b1, 8'h10, 1'b0);
    @(negedge clk);
    checks++;
    if (o_val !== 1'b1 || o_sel !== SW'(1) || o_dat !== 8'h10) begin
      failures++; $display("FAIL bubble_first got val=%b sel=%0d dat=%h exp val=1 sel=1 dat=10", o_val, o_sel, o_dat);
    end
    next_cycle();
    put(1, 1'b0, '0, 1'b0);
    put(0, 1'b1, 8'h00, 1'b1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checks++;
      if (o_val !== 1'b0 || o_sel !== SW'(1) || i_rdy !== 4'b0010) begin
        failures++;
        $display("FAIL bubble_hold%0d got val=%b sel=%0d rdy=%b exp val=0 sel=1 rdy=0010", b, o_val, o_sel, i_rdy);
      end
      next_cycle();
    end
    put(1, 1'b1, 8'h11, 1'b1);
    @(negedge clk);
    checks++;
    if (o_val !== 1'b1 || o_sel !== SW'(1) || o_eop !== 1'b1 || o_dat !== 8'h11) begin
      failures++; $display("FAIL bubble_eop got val=%b sel=%0d eop=%b dat=%h exp 1/1/1/11", o_val, o_sel, o_eop, o_dat);
    end
    next_cycle();
    put(1, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_val !== 1'b1 || o_sel !== SW'(0) || o_dat !== 8'h00) begin
      failures++; $display("FAIL bubble_next got val=%b sel=%0d dat=%h exp val=1 sel=0 dat=00", o_val, o_sel, o_dat);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] prev;
    bit stalled;
    int got;
    bit pat [12] = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    got = 0; stalled = 0; prev = '0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      o_rdy = pat[c];
      put(0, 1'b1, DW'(8'hC0 + got), got == 3);
      @(negedge clk);
      if (stalled) begin
        checks++; if (o_dat !== prev) begin failures++; $display("FAIL bp_stable got=%h exp=%h", o_dat, prev); end
      end
      if (o_val && o_rdy) begin
        checks++;
        if (o_dat !== DW'(8'hC0 + got) || o_eop !== (got == 3)) begin
          failures++; $display("FAIL bp_word%0d got dat=%h eop=%b exp dat=%h eop=%b", got, o_dat, o_eop, DW'(8'hC0 + got), got == 3);
        end
        got++;
      end
      stalled = o_val && !o_rdy;
      prev = o_dat;
      next_cycle();
    end
    checks++; if (got != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
    clear_inputs();
  endtask

  task automatic test_single_word();
    do_reset();
    o_rdy = 1'b1;
    put(0, 1'b1, 8'h0F, 1'b1);
    put(3, 1'b1, 8'h3F, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (o_val !== 1'b1 || o_sel !== SW'((c % 2 == 0) ? 0 : 3)) begin
        failures++; $display("FAIL single_word_c%0d got val=%b sel=%0d exp val=1 sel=%0d", c, o_val, o_sel, (c % 2 == 0) ? 0 : 3);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    o_rdy = 1'b1;
    for (int w = 0; w < 2; w++) begin
      put(2, 1'b1, DW'(8'hE0 + w), 1'b0);
      @(negedge clk);
      checks++;
      if (o_sel !== SW'(2) || o_dat !== DW'(8'hE0 + w)) begin
        failures++; $display("FAIL rmid_word%0d got sel=%0d dat=%h exp sel=2 dat=%h", w, o_sel, o_dat, DW'(8'hE0 + w));
      end
      next_cycle();
    end
    reset = 1'b0;
    put(2, 1'b1, 8'hE2, 1'b0);
    put(0, 1'b1, 8'h77, 1'b1);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      checks++;
      if (i_rdy !== '0 || o_val !== 1'b0) begin
        failures++; $display("FAIL rmid_during_reset got rdy=%b val=%b exp rdy=0 val=0", i_rdy, o_val);
      end
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_val !== 1'b1 || o_sel !== SW'(0) || o_dat !== 8'h77) begin
      failures++; $display("FAIL rmid_after got val=%b sel=%0d dat=%h exp val=1 sel=0 dat=77", o_val, o_sel, o_dat);
    end
    next_cycle();
    put(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_val !== 1'b1 || o_sel !== SW'(2) || o_dat !== 8'hE2) begin
      failures++; $display("FAIL rmid_resume got val=%b sel=%0d dat=%h exp val=1 sel=2 dat=E2", o_val, o_sel, o_dat);
    end
    next_cycle();
    clear_inputs();
  endtask

  // Reference: packet-level round-robin over per-source word arrays.
  task automatic test_random();
    logic [DW:0]  mem [N][64];
    int           rd [N];
    int           wr [N];
    bit           pres [N];
    int           own, ptr, expg, np, len, left;
    logic [N-1:0] er;
    logic [DW:0]  wrd;
    do_reset();
    own = -1; ptr = 0;
    for (int k = 0; k < N; k++) begin
      rd[k] = 0; wr[k] = 0; pres[k] = 0;
      np = $urandom_range(5, 2);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(4, 1);
        for (int w = 0; w < len; w++) begin
          mem[k][wr[k]] = {w == len - 1, DW'($urandom)};
          wr[k]++;
        end
      end
    end
    for (int c = 0; c < 3000; c++) begin
      left = 0;
      for (int k = 0; k < N; k++) left += wr[k] - rd[k];
      if (left == 0) break;
      for (int k = 0; k < N; k++) begin
        if (!pres[k] && rd[k] < wr[k] && $urandom_range(3) != 0) pres[k] = 1;
        if (pres[k]) put(k, 1'b1, mem[k][rd[k]][DW-1:0], mem[k][rd[k]][DW]);
        else         put(k, 1'b0, DW'($urandom), 1'b0);
      end
      o_rdy = ($urandom_range(3) != 0);
      @(negedge clk);
      expg = -1;
      if (own >= 0) begin
        if (pres[own]) expg = own;
      end else begin
        for (int i = 0; i < N; i++) if (expg < 0 && pres[(ptr + i) % N]) expg = (ptr + i) % N;
      end
      er = '0;
      if (own >= 0) er[own] = o_rdy;
      else if (expg >= 0) er[expg] = o_rdy;
      checks++;
      if (expg < 0) begin
        if (o_val !== 1'b0) begin failures++; $display("FAIL rand_idle c=%0d got val=%b exp val=0", c, o_val); end
      end else begin
        wrd = mem[expg][rd[expg]];
        if (o_val !== 1'b1 || o_sel !== SW'(expg) || o_dat !== wrd[DW-1:0] || o_eop !== wrd[DW]) begin
          failures++;
          $display("FAIL rand_out c=%0d got val=%b sel=%0d dat=%h eop=%b exp val=1 sel=%0d dat=%h eop=%b",
                   c, o_val, o_sel, o_dat, o_eop, expg, wrd[DW-1:0], wrd[DW]);
        end
      end
      checks++;
      if (i_rdy !== er) begin failures++; $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, i_rdy, er); end
      if (expg >= 0 && o_rdy) begin
        wrd = mem[expg][rd[expg]];
        rd[expg]++;
        pres[expg] = 0;
        if (wrd[DW]) begin
          own = -1;
          ptr = (expg + 1) % N;
        end else begin
          own = expg;
        end
      end
      next_cycle();
    end
    left = 0;
    for (int k = 0; k < N; k++) left += wr[k] - rd[k];
    checks++; if (left != 0) begin failures++; $display("FAIL rand_drain got left=%0d exp=0", left); end
    clear_inputs();
  endtask

  task automatic test_outreg_contention();
    int widx [N];
    int es, ew;
    do_reset();
    o_rdy = 1'b1;
    for (int k = 0; k < N; k++) widx[k] = 0;
    for (int c = 0; c < 11; c++) begin
      for (int k = 0; k < N; k++) put(k, 1'b1, DW'((k << 4) | widx[k]), widx[k] == 1);
      @(negedge clk);
      checks++;
      if (c == 0) begin
        if (o_val !== 1'b0) begin failures++; $display("FAIL outreg_latency got val=%b exp=0", o_val); end
      end else begin
        es = ((c - 1) / 2) % N;
        ew = (c - 1) % 2;
        if (o_val !== 1'b1 || o_sel !== SW'(es) || o_dat !== DW'((es << 4) | ew) || o_eop !== (ew == 1)) begin
          failures++;
          $display("FAIL outreg_c%0d got val=%b sel=%0d dat=%h exp val=1 sel=%0d dat=%h", c, o_val, o_sel, o_dat, es, DW'((es << 4) | ew));
        end
      end
      for (int k = 0; k < N; k++) if (i_rdy[k]) widx[k] = (widx[k] + 1) % 2;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    test_reset();
`ifdef PS_PACKET_ARBITER_OUTREG_EN
    test_outreg_contention();
`else
    test_single_source();
    test_contention();
    test_bubble();
    test_backpressure();
    test_single_word();
    test_reset_mid();
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps_packet_arbiter.md
Name: ps_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one PacketStream sink among INPUTS PacketStream sources.
- Typical use: merging several extracted-header or payload streams ahead of a single downstream consumer.
- The grant locks for the whole packet (first word through eop), so packets are never interleaved.
- Datapath is a combinational mux: zero latency when the optional output register is not compiled in.

Parameters:
- DWIDTH, 8: stream data width.
- INPUTS, 4: number of source ports, 2..16.
- SWIDTH, $clog2(INPUTS): width of the selected-source index. Derived; not overridden.

Ports:
- reset  input  1  asynchronous reset, active-low (asserted at 0).
- clk  input  1  clock.
- i_dat  input  INPUTS*DWIDTH  source data; source k occupies bits [k*DWIDTH +: DWIDTH].
- i_val  input  INPUTS  source valid, one bit per source.
- i_eop  input  INPUTS  source end-of-packet, one bit per source.
- i_rdy  output  INPUTS  source ready, one bit per source.
- o_dat  output  DWIDTH  sink data.
- o_val  output  1  sink valid.
- o_eop  output  1  sink end-of-packet.
- o_rdy  input  1  sink ready.
- o_sel  output  SWIDTH  index of the source currently granted; meaningful only while o_val=1.

Behaviour:
- Transfer on any interface occurs when val & rdy are both 1 on a clk edge.
- State registers:
  - lock_reg: 0 = IDLE, 1 = LOCKED.
  - sel_reg: granted source index.
  - ptr_reg: round-robin priority pointer.
- Reset values: lock_reg=0, sel_reg=0, ptr_reg=0. During reset all i_rdy=0, o_val=0, o_eop=0, o_sel=0.
- IDLE, grant selection (combinational):
  - gnt = first k with i_val[k]=1, scanning ptr_reg, ptr_reg+1, ..., INPUTS-1, 0, ..., ptr_reg-1 (modulo INPUTS).
  - If no i_val is set, o_val=0 and all i_rdy=0.
- LOCKED: gnt = sel_reg, independent of the other i_val bits.
- Datapath (combinational):
  - o_dat = i_dat[gnt], o_val = i_val[gnt], o_eop = i_eop[gnt], o_sel = gnt.
  - i_rdy[gnt] = o_rdy; every other i_rdy bit = 0.
- Transitions, evaluated on a sink transfer only:
  - IDLE, transfer with o_eop=0: lock_reg<=1, sel_reg<=gnt.
  - IDLE, transfer with o_eop=1 (single-word packet): stay IDLE, ptr_reg<=gnt+1 (mod INPUTS).
  - LOCKED, transfer with o_eop=1: lock_reg<=0, ptr_reg<=sel_reg+1 (mod INPUTS).
  - LOCKED, transfer with o_eop=0: no change.
  - No transfer: all registers hold.
- Pointer wrap: modulo INPUTS, correct for non-power-of-2 INPUTS. The value INPUTS is never reached.
- LOCKED with the granted source's i_val=0 (bubble): o_val=0, the grant is held, and other sources stay blocked.
- o_rdy=0 with o_val=1: o_dat, o_eop and o_sel stay stable while the source holds its data. The IDLE grant may change only if the source deasserts val, which is a protocol violation upstream.
- Reset mid-packet: the lock is dropped immediately. The remainder of the interrupted packet is treated as a new packet on its next word.
- Fairness: with all sources continuously valid, packets are granted in order 0,1,2,...,INPUTS-1,0,... regardless of packet length.

Optional Feature:
- Macro: PS_PACKET_ARBITER_OUTREG_EN.
- Defined:
  - Adds a two-entry skid register stage on o_dat/o_val/o_eop/o_sel.
  - Adds one cycle of latency.
  - Full throughput is sustained under continuous o_rdy=1.
  - The internal mux ready is the skid "not full" flag, so no combinational path from o_rdy to i_rdy.
  - Arbitration state advances on the internal mux transfer, not the sink transfer.
  - Reset clears the stage (o_val=0).
- Undefined: purely combinational datapath as above; zero latency.

Test Plan:
- Single source: INPUTS=4, only source 2 sends a 3-word packet A0,A1,A2(eop) with o_rdy=1 -> o_dat=A0,A1,A2 on consecutive cycles, o_sel=2, o_eop on the 3rd word, ptr_reg=3 afterwards.
- Contention: all four sources continuously valid, each sending 2-word packets -> sink sees complete packets in source order 0,1,2,3,0, never interleaved; i_rdy is one-hot or zero every cycle.
- Bubble while locked: source 1 sends word 0, drops i_val for 3 cycles, then sends eop while source 0 stays valid -> o_val=0 for 3 cycles, o_sel stays 1, and source 0 is granted only after source 1's eop.
- Backpressure: o_rdy toggles 1,0,0,1 during a 4-word packet -> no word lost or duplicated; o_dat is stable while o_rdy=0.
- Single-word packets: sources 0 and 3 each send 1-word eop packets continuously -> grants alternate 0,3,0,3 with no idle cycles.
- Reset mid-packet: assert reset for 2 cycles after word 1 of a 4-word packet from source 2 -> i_rdy=0 and o_val=0 during reset; after release ptr_reg=0 and source 0 wins if valid. With PS_PACKET_ARBITER_OUTREG_EN, repeat the contention test and check 1-cycle latency and full throughput.
